// File: rtl/intc_pkg.sv
// Shared types and constants for the interrupt controller slice.
package intc_pkg;

    localparam int unsigned INTC_NUM_SOURCES = 4;
    localparam int unsigned TIMER0_INT_IDX   = 0;
    localparam int unsigned TIMER1_INT_IDX   = 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        SERVICE = 2'd2
    } state_e;

endpackage

// File: rtl/interrupt_priority_encoder.sv
// Combinational fixed-priority encoder: lowest set index wins.
module interrupt_priority_encoder
    import intc_pkg::*;
#(
    parameter int unsigned NUM_SOURCES = INTC_NUM_SOURCES,
    parameter int unsigned ID_WIDTH    = $clog2(NUM_SOURCES)
) (
    input  logic [NUM_SOURCES-1:0] req_vec,
    output logic                   any_valid_c,
    output logic [ID_WIDTH-1:0]    lowest_idx_c
);

    // Scan from the top down so the lowest set index is the last write.
    always_comb begin
        any_valid_c  = |req_vec;
        lowest_idx_c = '0;
        for (int i = int'(NUM_SOURCES) - 1; i >= 0; i--) begin
            if (req_vec[i]) begin
                lowest_idx_c = ID_WIDTH'(i);
            end
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// Edge-latching interrupt controller with fixed-priority dispatch and a
// valid/ack/done handshake to the core; one handler in service at a time.
module interrupt_controller
    import intc_pkg::*;
#(
    parameter int unsigned NUM_SOURCES = INTC_NUM_SOURCES,
    parameter int unsigned ID_WIDTH    = $clog2(NUM_SOURCES)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   global_enable,
    input  logic [NUM_SOURCES-1:0] source_request,
    input  logic [NUM_SOURCES-1:0] source_mask,
    input  logic [NUM_SOURCES-1:0] pending_clear,
    output logic                   irq_valid,
    output logic [ID_WIDTH-1:0]    irq_id,
    input  logic                   irq_ack,
    input  logic                   irq_done,
    output logic [NUM_SOURCES-1:0] pending_status,
    output logic                   in_service
);

    state_e                  state_q, state_d;
    logic [NUM_SOURCES-1:0]  prev_request_q, prev_request_d;
    logic [NUM_SOURCES-1:0]  pending_q, pending_d;
    logic [ID_WIDTH-1:0]     irq_id_q, irq_id_d;
    logic                    irq_valid_q, irq_valid_d;
    logic                    in_service_q, in_service_d;

    logic [NUM_SOURCES-1:0]  req_edge;
    logic [NUM_SOURCES-1:0]  ack_clear;
    logic [NUM_SOURCES-1:0]  eligible;
    logic                    ack_taken;
    logic                    win_valid_c;
    logic [ID_WIDTH-1:0]     win_idx_c;

    interrupt_priority_encoder #(
        .NUM_SOURCES (NUM_SOURCES),
        .ID_WIDTH    (ID_WIDTH)
    ) u_prio (
        .req_vec      (eligible),
        .any_valid_c  (win_valid_c),
        .lowest_idx_c (win_idx_c)
    );

    // Pending capture: new edges win over software and ack clears.
    always_comb begin
        req_edge       = source_request & ~prev_request_q;
        prev_request_d = source_request;
        ack_clear      = '0;
        if (ack_taken) begin
            ack_clear = NUM_SOURCES'(1) << irq_id_q;
        end
        pending_d = (pending_q & ~pending_clear & ~ack_clear) | req_edge;
        eligible  = global_enable ? (pending_q & source_mask) : '0;
    end

    // Dispatch FSM; outputs are decoded from the next state and registered.
    always_comb begin
        state_d   = state_q;
        irq_id_d  = irq_id_q;
        ack_taken = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (win_valid_c) begin
                    state_d  = REQUEST;
                    irq_id_d = win_idx_c;
                end
            end
            REQUEST: begin
                if (irq_ack) begin
                    state_d   = SERVICE;
                    ack_taken = 1'b1;
                end
            end
            SERVICE: begin
                if (irq_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        irq_valid_d  = (state_d == REQUEST);
        in_service_d = (state_d == SERVICE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            prev_request_q <= '0;
            pending_q      <= '0;
            irq_id_q       <= '0;
            irq_valid_q    <= 1'b0;
            in_service_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            prev_request_q <= prev_request_d;
            pending_q      <= pending_d;
            irq_id_q       <= irq_id_d;
            irq_valid_q    <= irq_valid_d;
            in_service_q   <= in_service_d;
        end
    end

    assign irq_valid      = irq_valid_q;
    assign irq_id         = irq_id_q;
    assign pending_status = pending_q;
    assign in_service     = in_service_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Self-checking bench: directed scenarios plus random traffic against a
// behavioural reference model of the controller.
module tb_interrupt_controller;

    logic       clk;
    logic       rst;
    logic       global_enable;
    logic [3:0] source_request;
    logic [3:0] source_mask;
    logic [3:0] pending_clear;
    logic       irq_valid;
    logic [1:0] irq_id;
    logic       irq_ack;
    logic       irq_done;
    logic [3:0] pending_status;
    logic       in_service;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    bit [3:0] m_prev;
    bit [3:0] m_pend;
    bit       m_valid;
    bit       m_serv;
    int       m_id;

    interrupt_controller #(.NUM_SOURCES(4), .ID_WIDTH(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .global_enable  (global_enable),
        .source_request (source_request),
        .source_mask    (source_mask),
        .pending_clear  (pending_clear),
        .irq_valid      (irq_valid),
        .irq_id         (irq_id),
        .irq_ack        (irq_ack),
        .irq_done       (irq_done),
        .pending_status (pending_status),
        .in_service     (in_service)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // One clock of the controller as the rules describe it.
    function automatic void model_update();
        bit [3:0] rise;
        bit [3:0] clr;
        bit [3:0] elig;
        if (rst) begin
            m_prev = '0; m_pend = '0; m_valid = 0; m_serv = 0; m_id = 0;
            return;
        end
        rise = source_request & ~m_prev;
        clr  = pending_clear;
        elig = global_enable ? (m_pend & source_mask) : 4'b0;
        if (m_valid) begin
            if (irq_ack) begin
                clr[m_id] = 1'b1;
                m_valid   = 0;
                m_serv    = 1;
            end
        end else if (m_serv) begin
            if (irq_done) m_serv = 0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (elig[i]) begin
                    m_id    = i;
                    m_valid = 1;
                    break;
                end
            end
        end
        m_pend = (m_pend & ~clr) | rise;
        m_prev = source_request;
    endfunction

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        check("model_valid", 32'(irq_valid), 32'(m_valid));
        check("model_serv",  32'(in_service), 32'(m_serv));
        check("model_pend",  32'(pending_status), 32'(m_pend));
        if (m_valid) check("model_id", 32'(irq_id), 32'(m_id));
    endtask

    // Act as the core until nothing is pending and the controller is idle.
    task automatic drain();
        int guard = 0;
        source_request = '0;
        source_mask    = 4'hF;
        global_enable  = 1'b1;
        while ((m_pend != 0 || m_valid || m_serv) && guard < 200) begin
            irq_ack  = m_valid;
            irq_done = m_serv;
            step();
            guard++;
        end
        irq_ack  = 1'b0;
        irq_done = 1'b0;
        check("drain_done", 32'(guard < 200), 32'd1);
    endtask

    initial begin
        int dispatches;
        int seen_valid;
        logic last_valid;

        rst = 1'b1; global_enable = 1'b1; source_request = '0;
        source_mask = 4'hF; pending_clear = '0; irq_ack = 1'b0; irq_done = 1'b0;
        step(); step();
        check("rst_valid", 32'(irq_valid), 32'd0);
        check("rst_id", 32'(irq_id), 32'd0);
        check("rst_pend", 32'(pending_status), 32'd0);
        check("rst_serv", 32'(in_service), 32'd0);
        rst = 1'b0;
        step();

        // Single event on source 2
        source_request = 4'b0100; step();
        check("se_pend", 32'(pending_status), 32'h4);
        step();
        check("se_valid", 32'(irq_valid), 32'd1);
        check("se_id", 32'(irq_id), 32'd2);
        step();
        source_request = '0; step();
        irq_ack = 1'b1; step(); irq_ack = 1'b0;
        check("se_serv", 32'(in_service), 32'd1);
        check("se_valid_low", 32'(irq_valid), 32'd0);
        check("se_pend_clr", 32'(pending_status), 32'h0);
        step(); step();
        irq_done = 1'b1; step(); irq_done = 1'b0;
        check("se_done", 32'(in_service), 32'd0);
        step();

        // Priority: sources 3 and 1 together
        source_request = 4'b1010; step(); source_request = '0; step();
        check("pr_id_first", 32'(irq_id), 32'd1);
        irq_ack = 1'b1; step(); irq_ack = 1'b0;
        check("pr_pend3", 32'(pending_status), 32'h8);
        irq_done = 1'b1; step(); irq_done = 1'b0;
        check("pr_gap", 32'(irq_valid), 32'd0);
        step();
        check("pr_valid2", 32'(irq_valid), 32'd1);
        check("pr_id_second", 32'(irq_id), 32'd3);
        drain();

        // Masked source 0, then unmask, then drop enable during REQUEST
        source_mask = 4'b1110; source_request = 4'b0001; step(); source_request = '0;
        seen_valid = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (irq_valid) seen_valid++;
        end
        check("mask_no_valid", 32'(seen_valid), 32'd0);
        check("mask_pend", 32'(pending_status), 32'h1);
        source_mask = 4'hF; step();
        check("unmask_valid", 32'(irq_valid), 32'd1);
        global_enable = 1'b0; source_mask = 4'h0; pending_clear = 4'b0001;
        step(); step(); step();
        pending_clear = '0;
        check("en_hold_valid", 32'(irq_valid), 32'd1);
        check("en_hold_id", 32'(irq_id), 32'd0);
        irq_ack = 1'b1; step(); irq_ack = 1'b0;
        check("en_ack_serv", 32'(in_service), 32'd1);
        drain();

        // Simultaneous set and clear
        source_request = 4'b0100; step(); source_request = '0; step();
        irq_ack = 1'b1; source_request = 4'b0100; step();
        irq_ack = 1'b0; source_request = '0;
        check("sc_ack_repend", 32'(pending_status), 32'h4);
        pending_clear = 4'b0010; source_request = 4'b0010; step();
        pending_clear = '0; source_request = '0;
        check("sc_clr_repend", 32'(pending_status), 32'h6);
        drain();

        // Held level: one dispatch over 200 cycles
        dispatches = 0; last_valid = 1'b0;
        source_request = 4'b0001;
        for (int i = 0; i < 200; i++) begin
            irq_ack  = m_valid;
            irq_done = m_serv;
            step();
            if (irq_valid && !last_valid) dispatches++;
            last_valid = irq_valid;
        end
        irq_ack = 1'b0; irq_done = 1'b0;
        check("held_dispatch", 32'(dispatches), 32'd1);
        // Held high through reset release
        rst = 1'b1; step(); step();
        check("held_rst_pend", 32'(pending_status), 32'h0);
        rst = 1'b0; step();
        check("held_after_rst", 32'(pending_status), 32'h1);
        drain();

        // Reset during SERVICE with 1010 pending
        source_request = 4'b0001; step(); source_request = '0; step();
        irq_ack = 1'b1; step(); irq_ack = 1'b0;
        source_request = 4'b1010; step(); source_request = '0;
        check("rs_pend", 32'(pending_status), 32'hA);
        check("rs_serv", 32'(in_service), 32'd1);
        rst = 1'b1; step(); rst = 1'b0;
        check("rs_serv0", 32'(in_service), 32'd0);
        check("rs_valid0", 32'(irq_valid), 32'd0);
        check("rs_pend0", 32'(pending_status), 32'h0);
        irq_done = 1'b1; step(); irq_done = 1'b0;
        check("rs_spur_done", 32'(in_service), 32'd0);
        check("rs_spur_valid", 32'(irq_valid), 32'd0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 2) == 0) source_request = 4'($urandom());
            if ($urandom_range(0, 30) == 0) source_mask = 4'($urandom());
            global_enable = ($urandom_range(0, 9) != 0);
            pending_clear = ($urandom_range(0, 15) == 0) ? 4'($urandom()) : 4'b0;
            irq_ack  = ($urandom_range(0, 2) == 0);
            irq_done = ($urandom_range(0, 3) == 0);
            rst      = ($urandom_range(0, 250) == 0);
            step();
        end
        rst = 1'b0; pending_clear = '0;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
